// File: rtl/kgp_lsu_pkg.sv
// Shared types and constants for the KGP-RISC load/store controller.
package kgp_lsu_pkg;

    localparam int unsigned LSU_ADDR_W     = 10;
    localparam int unsigned LSU_DATA_W     = 32;
    // Byte offset inside a word; word-only accesses drop these bits.
    localparam int unsigned LSU_BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_addr_check.sv
// Byte-address decoder: splits out the word index and flags misaligned or out-of-range
// addresses. Only instantiated when LSU_ADDR_CHECK_EN is defined.
module lsu_addr_check
    import kgp_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W
) (
    input  logic [31:0]       byte_addr_i,
    output logic [ADDR_W-1:0] word_idx_o,
    output logic              fault_o
);

    assign word_idx_o = byte_addr_i[ADDR_W+LSU_BYTE_OFF_W-1:LSU_BYTE_OFF_W];

    // Fault on a non-word-aligned address or on any bit beyond the memory's reach.
    assign fault_o = (|byte_addr_i[LSU_BYTE_OFF_W-1:0])
                   | (|byte_addr_i[31:ADDR_W+LSU_BYTE_OFF_W]);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the execute stage and a single-port block RAM.
// One transaction in flight; absorbs the one-cycle synchronous read latency.
// Optional feature: define LSU_ADDR_CHECK_EN to fault misaligned/out-of-range addresses.
module lsu_ctrl
    import kgp_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] req_idx;
    logic              req_fault;

`ifdef LSU_ADDR_CHECK_EN
    lsu_addr_check #(
        .ADDR_W (ADDR_W)
    ) u_addr_check (
        .byte_addr_i (req_addr),
        .word_idx_o  (req_idx),
        .fault_o     (req_fault)
    );
`else
    assign req_idx   = req_addr[ADDR_W+LSU_BYTE_OFF_W-1:LSU_BYTE_OFF_W];
    assign req_fault = 1'b0;

    // Offset and high address bits are deliberately ignored without the checker.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+LSU_BYTE_OFF_W],
                                req_addr[LSU_BYTE_OFF_W-1:0]};
`endif

    // Next-state, capture and output decode for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_idx;
                    wdata_d = req_wdata;
                    // Stores and faults report zero data.
                    rdata_d = '0;
                    err_d   = req_fault;
                    state_d = req_fault ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_read  = ~we_q;
                mem_write = we_q;
                state_d   = we_q ? RESP : WAIT;
            end
            WAIT: begin
                // RAM output is valid one cycle after the address was sampled.
                rdata_d = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_we    = we_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed scenarios plus randomized transactions checked against
// a word-array reference model. Honors LSU_ADDR_CHECK_EN like the design.
module tb_lsu_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_we;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    logic [DW-1:0] dmem    [1024];
    logic [DW-1:0] ref_mem [1024];

    lsu_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_we    (resp_we),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM stand-in: synchronous read, garbage on the data bus when not reading.
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= dmem[mem_addr];
        else mem_rdata <= $urandom;
    end

    // Bus monitor: counts enable cycles and checks the bus is parked at zero when disabled.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
            end
            if (!mem_read && !mem_write) begin
                n_cmp++;
                if (mem_addr !== '0 || mem_wdata !== '0) begin
                    n_fail++;
                    $display("FAIL idle_bus: got addr=%h wdata=%h, want 0/0", mem_addr, mem_wdata);
                end
            end
        end
    end

    function automatic logic is_fault(input logic [31:0] a);
`ifdef LSU_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
`else
        return 1'b0;
`endif
    endfunction

    // One complete transaction with optional response backpressure, checked against the model.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [DW-1:0] wd,
                           input int hold, input string name);
        logic          flt;
        logic [AW-1:0] idx;
        logic [DW-1:0] exp_rd;
        int            lat, exp_lat, rd0, wr0;
        flt     = is_fault(addr);
        idx     = addr[AW+1:2];
        exp_rd  = (we || flt) ? '0 : ref_mem[idx];
        exp_lat = flt ? 1 : (we ? 2 : 3);
        if (we && !flt) ref_mem[idx] = wd;

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b0;
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: got req_ready=%b, want 1", name, req_ready);
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if ({resp_valid, resp_we, resp_err, resp_rdata} !== {1'b1, we, flt, exp_rd}) begin
            n_fail++;
            $display("FAIL %s resp: got v=%b we=%b err=%b rdata=%h, want 1/%b/%b/%h",
                     name, resp_valid, resp_we, resp_err, resp_rdata, we, flt, exp_rd);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({resp_valid, req_ready, busy, resp_rdata} !== {3'b101, exp_rd}) begin
                n_fail++;
                $display("FAIL %s hold%0d: got v=%b rdy=%b busy=%b rdata=%h, want 1/0/1/%h",
                         name, i, resp_valid, req_ready, busy, resp_rdata, exp_rd);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        n_cmp++;
        if ({resp_valid, req_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s handshake: got v=%b rdy=%b busy=%b, want 0/1/0",
                     name, resp_valid, req_ready, busy);
        end
        n_cmp++;
        if ((rd_cnt - rd0) != int'(!we && !flt) || (wr_cnt - wr0) != int'(we && !flt)) begin
            n_fail++;
            $display("FAIL %s pulses: got rd=%0d wr=%0d, want %0d/%0d", name, rd_cnt - rd0,
                     wr_cnt - wr0, int'(!we && !flt), int'(we && !flt));
        end
        if (we && !flt) begin
            n_cmp++;
            if (last_wr_addr !== idx || last_wr_data !== wd) begin
                n_fail++;
                $display("FAIL %s wr_bus: got addr=%h data=%h, want %h/%h",
                         name, last_wr_addr, last_wr_data, idx, wd);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        #3;
        n_cmp++;
        if ({req_ready, resp_valid, resp_we, resp_err, busy, mem_read, mem_write} !== 7'b1000000
            || resp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b v=%b busy=%b rd=%b wr=%b rdata=%h addr=%h, want 1/0/0/0/0/0/0",
                     req_ready, resp_valid, busy, mem_read, mem_write, resp_rdata, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_store_load();
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, "store_10");
        run_txn(1'b0, 32'h0000_0010, '0, 0, "load_10");
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 32'h0000_0010, '0, 5, "backpressure");
    endtask

    task automatic test_back_to_back();
        int lat, rd0;
        rd0 = rd_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 32'h4;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({busy, req_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_accept%0d: got busy=%b rdy=%b, want 1/0", k, busy, req_ready);
            end
            if (k == 1) req_valid = 1'b0;
            lat = 1;
            while (!resp_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_cmp++;
            if (lat != 3 || resp_rdata !== ref_mem[k]) begin
                n_fail++;
                $display("FAIL b2b_resp%0d: got lat=%0d rdata=%h, want 3/%h",
                         k, lat, resp_rdata, ref_mem[k]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({resp_valid, req_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL b2b_hs%0d: got v=%b rdy=%b, want 0/1", k, resp_valid, req_ready);
            end
            if (k == 0) begin
                @(posedge clk);
                #1;
            end
        end
        resp_ready = 1'b0;
        req_addr   = '0;
        n_cmp++;
        if (rd_cnt - rd0 != 2) begin
            n_fail++;
            $display("FAIL b2b_reads: got %0d read cycles, want 2", rd_cnt - rd0);
        end
    endtask

    task automatic test_reset_in_wait();
        logic saw_valid;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h20;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, resp_valid, mem_read} !== 3'b100) begin
            n_fail++;
            $display("FAIL wait_state: got busy=%b v=%b rd=%b, want 1/0/0", busy, resp_valid, mem_read);
        end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, resp_we, resp_err, busy, mem_read, mem_write} !== 7'b1000000
            || resp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_wait: got rdy=%b v=%b busy=%b rd=%b rdata=%h, want 1/0/0/0/0",
                     req_ready, resp_valid, busy, mem_read, resp_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (resp_valid || !req_ready) saw_valid = 1'b1;
        end
        n_cmp++;
        if (saw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_resp: got stray response/not-ready=%b, want 0", saw_valid);
        end
    endtask

    task automatic test_addr_check();
`ifdef LSU_ADDR_CHECK_EN
        run_txn(1'b0, 32'h0000_0013, '0, 0, "fault_misaligned");
        run_txn(1'b0, 32'h0000_1000, '0, 1, "fault_range");
        run_txn(1'b1, 32'h0000_0012, 32'h1234_5678, 0, "fault_store");
`else
        run_txn(1'b0, 32'h0000_0013, '0, 0, "trunc_0x13");
        run_txn(1'b1, 32'hFFFF_F00A, 32'h1234_5678, 0, "trunc_store");
        run_txn(1'b0, 32'h0000_0008, '0, 0, "trunc_load");
`endif
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({mem_addr, mem_read, mem_write, busy, req_ready} !== {{AW{1'b0}}, 4'b0001}) begin
                n_fail++;
                $display("FAIL idle%0d: got addr=%h rd=%b wr=%b busy=%b rdy=%b, want 0/0/0/0/1",
                         i, mem_addr, mem_read, mem_write, busy, req_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, a;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            a = ($urandom_range(0, 3) == 0) ? r : {20'd0, r[11:2], 2'b00};
            run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v = $urandom;
            dmem[i]    <= v;
            ref_mem[i] = v;
        end
        test_reset();
        test_store_load();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        test_addr_check();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
